// File: rtl/decoder_pkg.sv
// Shared types for the scanning one-hot decoder: operating modes and controller states.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_SCAN_UP = 2'b01,
    MODE_SCAN_DN = 2'b10,
    MODE_SWEEP   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    DIRECT,
    SCAN,
    SWEEP,
    DONE
  } state_e;

  // State entered from IDLE (or on a mode change) for a given mode.
  function automatic state_e entry_state(mode_e m);
    unique case (m)
      MODE_DIRECT:                 return DIRECT;
      MODE_SCAN_UP, MODE_SCAN_DN:  return SCAN;
      default:                     return SWEEP;
    endcase
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder; all zeros when not enabled.
module onehot_dec #(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]      inpt,
  input  logic                  enb,
  output logic [2**SEL_W-1:0]   out
);

  always_comb begin
    out = '0;
    if (enb) out[inpt] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct, scan-up, scan-down and single-sweep modes,
// each scanned index held for hold+1 cycles.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned HOLD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     inpt,
  input  logic                 load,
  input  logic [HOLD_W-1:0]    hold,
  output logic [2**SEL_W-1:0]  out,
  output logic [SEL_W-1:0]     idx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned OUT_W = 2**SEL_W;

  localparam logic [SEL_W-1:0]  IdxMax = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0]  IdxOne = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] CntOne = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  mode_e               mode_q, mode_in;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]    idx_d;
  logic                done_d, busy_d, out_en, dwell_up;
  logic [OUT_W-1:0]    out_d;

  assign mode_in  = mode_e'(mode);
  assign dwell_up = (cnt_q >= hold);

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (!enb) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || mode_in != mode_q) begin
      // Mode change re-enters through the IDLE rules in the same cycle.
      state_d = entry_state(mode_in);
      idx_d   = inpt;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DIRECT: idx_d = inpt;
        SCAN: begin
          if (load) begin
            idx_d = inpt;
            cnt_d = '0;
          end else if (dwell_up) begin
            cnt_d = '0;
            idx_d = (mode_q == MODE_SCAN_DN) ? idx - IdxOne : idx + IdxOne;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        SWEEP: begin
          if (load) begin
            idx_d = inpt;
            cnt_d = '0;
          end else if (dwell_up) begin
            cnt_d = '0;
            if (idx == IdxMax) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx + IdxOne;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        DONE: begin
          if (load) begin
            state_d = SWEEP;
            idx_d   = inpt;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    out_en = (state_d == DIRECT) || (state_d == SCAN) || (state_d == SWEEP);
    busy_d = (state_d == SCAN) || (state_d == SWEEP);
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .inpt (idx_d),
    .enb  (out_en),
    .out  (out_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_DIRECT;
      cnt_q   <= '0;
      idx     <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_in;
      cnt_q   <= cnt_d;
      idx     <= idx_d;
      out     <= out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two widths driven in parallel, directed scenarios then random stimulus.
module tb_decoder_scan;

  localparam int K_IDLE   = 0;
  localparam int K_DIRECT = 1;
  localparam int K_SCAN   = 2;
  localparam int K_SWEEP  = 3;
  localparam int K_DONE   = 4;

  typedef struct packed {
    int kind;
    int pos;
    int elapsed;
    int last_mode;
    bit done;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst, enb, load;
  logic [1:0] mode;
  logic [7:0] hold;
  logic [1:0] inpt_a;
  logic [2:0] inpt_b;

  logic [3:0] out_a;
  logic [1:0] idx_a;
  logic       busy_a, done_a;
  logic [7:0] out_b;
  logic [2:0] idx_b;
  logic       busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .HOLD_W(8)) dut_a (
    .clk (clk), .rst (rst), .enb (enb), .mode (mode), .inpt (inpt_a), .load (load),
    .hold (hold), .out (out_a), .idx (idx_a), .busy (busy_a), .done (done_a)
  );

  decoder_scan #(.SEL_W(3), .HOLD_W(8)) dut_b (
    .clk (clk), .rst (rst), .enb (enb), .mode (mode), .inpt (inpt_b), .load (load),
    .hold (hold), .out (out_b), .idx (idx_b), .busy (busy_b), .done (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    return r;
  endfunction

  // Behavioural reference: position on a ring of n outputs, cycles spent on it so far.
  function automatic mdl_t mdl_step(mdl_t m, int n, bit e, int md, int in_v, bit ld, int hd);
    mdl_t r = m;
    r.done      = 1'b0;
    r.last_mode = md;
    if (!e) begin
      r.kind    = K_IDLE;
      r.elapsed = 0;
    end else if (m.kind == K_IDLE || md != m.last_mode) begin
      r.kind    = (md == 0) ? K_DIRECT : (md == 3) ? K_SWEEP : K_SCAN;
      r.pos     = in_v;
      r.elapsed = 0;
    end else if (m.kind == K_DIRECT) begin
      r.pos = in_v;
    end else if (m.kind == K_DONE) begin
      if (ld) begin
        r.kind    = K_SWEEP;
        r.pos     = in_v;
        r.elapsed = 0;
      end
    end else if (ld) begin
      r.pos     = in_v;
      r.elapsed = 0;
    end else if (m.elapsed >= hd) begin
      r.elapsed = 0;
      if (m.kind == K_SCAN) r.pos = (m.pos + ((md == 2) ? n - 1 : 1)) % n;
      else if (m.pos == n - 1) begin
        r.kind = K_DONE;
        r.done = 1'b1;
      end else r.pos = m.pos + 1;
    end else begin
      r.elapsed = m.elapsed + 1;
    end
    return r;
  endfunction

  function automatic int mdl_out(mdl_t m);
    return (m.kind == K_DIRECT || m.kind == K_SCAN || m.kind == K_SWEEP) ? (1 << m.pos) : 0;
  endfunction

  function automatic int mdl_busy(mdl_t m);
    return (m.kind == K_SCAN || m.kind == K_SWEEP) ? 1 : 0;
  endfunction

  task automatic compare_all();
    check("a_out",  32'(out_a),  32'(mdl_out(ma)));
    check("a_idx",  32'(idx_a),  32'(ma.pos));
    check("a_busy", 32'(busy_a), 32'(mdl_busy(ma)));
    check("a_done", 32'(done_a), 32'(ma.done));
    check("b_out",  32'(out_b),  32'(mdl_out(mb)));
    check("b_idx",  32'(idx_b),  32'(mb.pos));
    check("b_busy", 32'(busy_b), 32'(mdl_busy(mb)));
    check("b_done", 32'(done_b), 32'(mb.done));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 4, enb, int'(mode), int'(inpt_a), load, int'(hold));
      mb = mdl_step(mb, 8, enb, int'(mode), int'(inpt_b), load, int'(hold));
    end
    #1;
    compare_all();
  endtask

  initial begin
    int seq_up[5]    = '{2, 3, 0, 1, 2};
    int seq_dn[9]    = '{2, 2, 2, 1, 1, 1, 128, 128, 128};
    int seq_sweep[6] = '{1, 1, 2, 2, 3, 3};

    rst = 1'b1; enb = 1'b0; mode = 2'd0; load = 1'b0; hold = 8'd0;
    inpt_a = 2'd0; inpt_b = 3'd0;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_idx", 32'(idx_a), 32'd0);
    compare_all();
    repeat (2) tick();
    rst = 1'b0;

    // Direct mode
    mode = 2'd0; enb = 1'b1; inpt_a = 2'd2;
    tick(); check("direct_2", 32'(out_a), 32'h4);
    inpt_a = 2'd3;
    tick(); check("direct_3", 32'(out_a), 32'h8);
    enb = 1'b0;
    tick(); check("direct_off", 32'(out_a), 32'h0);

    // Scan-up wrap, hold 0
    mode = 2'd1; hold = 8'd0; inpt_a = 2'd2; enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("scan_up_idx", 32'(idx_a), 32'(seq_up[i]));
      check("scan_up_busy", 32'(busy_a), 32'd1);
    end
    enb = 1'b0;
    tick();

    // Scan-down with dwell on the 3-bit instance
    mode = 2'd2; hold = 8'd2; inpt_b = 3'd1; enb = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("scan_dn_out", 32'(out_b), 32'(seq_dn[i]));
    end
    enb = 1'b0;
    tick();

    // Single sweep, hold 1
    mode = 2'd3; hold = 8'd1; inpt_a = 2'd1; enb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sweep_idx", 32'(idx_a), 32'(seq_sweep[i]));
    end
    tick();
    check("sweep_end_out", 32'(out_a), 32'd0);
    check("sweep_end_done", 32'(done_a), 32'd1);
    tick();
    check("sweep_hold_out", 32'(out_a), 32'd0);
    check("sweep_hold_done", 32'(done_a), 32'd0);
    enb = 1'b0;
    tick();

    // Load overrides the dwell step
    mode = 2'd1; hold = 8'd0; inpt_a = 2'd1; enb = 1'b1;
    tick(); check("load_pre_idx", 32'(idx_a), 32'd1);
    load = 1'b1; inpt_a = 2'd3;
    tick(); check("load_idx", 32'(idx_a), 32'd3);
    load = 1'b0;
    tick(); check("load_after_idx", 32'(idx_a), 32'd0);

    // Asynchronous reset mid-scan, then a mode change into direct
    #2 rst = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    check("arst_out", 32'(out_a), 32'd0);
    check("arst_idx", 32'(idx_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    tick();
    rst = 1'b0; mode = 2'd1; inpt_a = 2'd2; enb = 1'b1;
    tick();
    tick();
    mode = 2'd0; inpt_a = 2'd0;
    tick(); check("mode_chg_out", 32'(out_a), 32'h1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        #2 rst = 1'b1;
        ma = mdl_reset();
        mb = mdl_reset();
        #1;
        check("rnd_arst_out", 32'(out_b), 32'd0);
      end
      enb  = ($urandom_range(15) != 0);
      load = ($urandom_range(19) == 0);
      if ($urandom_range(9) == 0)  mode = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) hold = 8'($urandom_range(3));
      inpt_a = 2'($urandom_range(3));
      inpt_b = 3'($urandom_range(7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder with enable. It generalises the team's 2x4 decoder with a select width parameter and three sequenced modes: scan-up, scan-down and single sweep, each with a programmable dwell per output. It sits in front of chip-select and LED/row-drive fabrics, where outputs must be glitch-free registered strobes.

## Interface
- `SEL_W`, default 2: select width; the block drives OUT_W = 2**SEL_W one-hot outputs (OUT_W is a derived localparam).
- `HOLD_W`, default 8: width of the dwell count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enb`  in  1  enable. When low, all outputs are forced off.
- `mode`  in  2  operating mode: 00 direct, 01 scan-up, 10 scan-down, 11 sweep.
- `inpt`  in  SEL_W  select in direct mode; start index for the scan and sweep modes.
- `load`  in  1  single-cycle pulse; restarts a scan or sweep from `inpt`.
- `hold`  in  HOLD_W  dwell per index, in cycles minus one (0 means advance every cycle).
- `out`  out  OUT_W  registered one-hot output, or all zeros.
- `idx`  out  SEL_W  registered current index.
- `busy`  out  1  high while in SCAN or SWEEP.
- `done`  out  1  one-cycle pulse when a sweep completes.

## Operation
- **Reset values:** `out`=0, `idx`=0, `busy`=0, `done`=0, dwell counter=0, state IDLE.
- **Priority each cycle:** `rst` > `enb`=0 > mode change > `load` > dwell step.
- **States:** IDLE, DIRECT, SCAN, SWEEP, DONE.
- **`enb`=0 in any state:** next state IDLE; `out`=0, `busy`=0, counter cleared, `idx` holds.
- **IDLE with `enb`=1, by mode:**
  - 00 → DIRECT.
  - 01 or 10 → SCAN.
  - 11 → SWEEP.
  - In every case `idx`<=`inpt`, `out`<=onehot(`inpt`) and the counter is cleared.
- **DIRECT:** `idx`<=`inpt` and `out`<=onehot(`inpt`) every cycle. `load` and `hold` are ignored.
- **SCAN:**
  - The counter increments each cycle.
  - When counter >= `hold` (live `hold` value), the counter clears and `idx` steps by +1 (mode 01) or -1 (mode 10), modulo OUT_W. Wrap-around: OUT_W-1→0 when scanning up, 0→OUT_W-1 when scanning down.
  - `out` always equals onehot(`idx`).
- **SWEEP:**
  - Steps upward exactly as in scan-up.
  - When the dwell expires with `idx`=OUT_W-1, there is no wrap. The next state is DONE, with `out`<=0 and `done`<=1 for that one cycle.
  - A sweep started at `inpt`=OUT_W-1 dwells once on that index, then completes.
- **DONE:** `out`=0, `busy`=0. Stays in DONE until `enb` falls, `mode` changes, or `load`. On `load` it restarts SWEEP from `inpt`.
- **`load` in SCAN or SWEEP:** `idx`<=`inpt`, counter cleared. This overrides a same-cycle dwell step.
- **`mode` change while `enb`=1 (outside IDLE):** the block re-enters through the IDLE entry rules in a single cycle, with no dead cycle. The new state, `idx`=`inpt`, counter cleared and `out`=onehot(`inpt`) all take effect on the edge where the new mode is sampled.
- **Width rules:**
  - The dwell counter is HOLD_W bits and never overflows, because it clears at `hold`.
  - `idx` arithmetic is SEL_W bits, with natural wrap.

## Timing
- **Latency:** 1 cycle from sampled inputs to `out`/`idx`; `out` is never combinational from the inputs.
- **`enb` rising at edge k:** `out` is valid after edge k.
- **`enb` falling at edge k:** `out`=0 after edge k.
- **Dwell:** each index is held for exactly `hold`+1 cycles in SCAN and SWEEP, provided `hold` is static.
- **`done`:** high for exactly one cycle, coincident with the first cycle of `out`=0.
- **`rst` mid-scan:** outputs clear immediately (asynchronously). After `rst` deasserts, the block re-enters through IDLE on the first edge with `enb`=1.
- **`busy`:** registered; it is 1 in the same cycles that state is SCAN or SWEEP.

## Structure
- **Package `decoder_pkg`:**
  - `mode_e` enum: MODE_DIRECT=2'b00, MODE_SCAN_UP=2'b01, MODE_SCAN_DN=2'b10, MODE_SWEEP=2'b11.
  - `state_e` enum: IDLE, DIRECT, SCAN, SWEEP, DONE.
- **Sub-module `onehot_dec`:** parametrised combinational decoder on SEL_W (input `inpt` plus `enb`, output one-hot). It is instantiated once on the next-`idx` value, and its result is registered into `out`.

## Test plan
1. **Direct mode:** SEL_W=2, `mode`=00, `enb`=1, `inpt`=2 → `out`=4'b0100 one cycle later. Then `inpt`=3 → 4'b1000. Then `enb`=0 → 4'b0000 on the next edge.
2. **Scan-up wrap:** SEL_W=2, `mode`=01, `hold`=0, `inpt`=2 → `idx` sequence 2,3,0,1,2 on consecutive cycles, with `busy`=1 throughout.
3. **Scan-down dwell:** SEL_W=3, `mode`=10, `hold`=2, `inpt`=1 → `out`=8'h02 for 3 cycles, then 8'h01 for 3 cycles, then 8'h80.
4. **Sweep:** SEL_W=2, `mode`=11, `hold`=1, `inpt`=1 → `idx` 1,1,2,2,3,3, then `out`=0 with `done`=1 for one cycle, then DONE holding `out`=0 and `done`=0.
5. **`load` vs step:** SEL_W=2, scan-up with `hold`=0 at `idx`=1, pulse `load` with `inpt`=3 → `idx`=3 next cycle, not 2.
6. **Mid-scan reset and mode change:**
   - Assert `rst` mid-scan → `out`, `idx`, `busy` and `done` are 0 before the next edge.
   - Mode change 01→00 with `inpt`=0 → `out`=4'b0001 on the next edge.
